alu_seq_p: RTL and testbench

ALU_SEQ_P -- requirements
Module: alu_seq_p

---
 rtl/alu_seq_p.sv | 135 +++++++++++++
 tb/tb_alu_seq_p.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_p.sv
// Sequential ALU: single-cycle logic/arith ops plus an N-step iterative unsigned multiply.
// Result and flags are registered; out_valid pulses once per completed op; in_ready is low while multiplying.
module alu_seq_p #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   select,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] result,
  output logic         out_valid,
  output logic         z,
  output logic         ov,
  output logic         c_out
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_ADD = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam int         CW     = $clog2(N + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [N-1:0]   mcand;
  logic           accept, mul_start, mul_last;
  logic [N:0]     add_sum, sub_diff, mul_sum;
  logic [2*N-1:0] acc_nxt;
  logic [N-1:0]   op_res;
  logic           op_c, op_ov;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (select == OP_MUL);
  assign mul_last  = (state == MUL) && (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (mul_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // Upper half of acc accumulates partial products; lower half holds the shifting multiplier.
  always_comb begin
    mul_sum = {1'b0, acc[2*N-1:N]} + {1'b0, mcand & {N{acc[0]}}};
    acc_nxt = {mul_sum, acc[N-1:1]};
  end

  always_comb begin
    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = {1'b0, a} - {1'b0, b};
    op_res   = a;
    op_c     = c_out;
    op_ov    = ov;
    case (select)
      OP_MOV: op_res = a;
      OP_NOT: op_res = ~a;
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_SUB: begin
        op_res = sub_diff[N-1:0];
        op_c   = ~sub_diff[N];
        op_ov  = (a[N-1] ^ b[N-1]) & (sub_diff[N-1] ^ a[N-1]);
      end
      OP_ADD: begin
        op_res = add_sum[N-1:0];
        op_c   = add_sum[N];
        op_ov  = ~(a[N-1] ^ b[N-1]) & (add_sum[N-1] ^ a[N-1]);
      end
      OP_SLT: op_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: op_res = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      z         <= 1'b1;
      ov        <= 1'b0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (mul_start) begin
          acc   <= {{N{1'b0}}, b};
          mcand <= a;
          cnt   <= '0;
        end else if (accept) begin
          result    <= op_res;
          z         <= (op_res == '0);
          c_out     <= op_c;
          ov        <= op_ov;
          out_valid <= 1'b1;
        end
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (mul_last) begin
          result    <= acc_nxt[N-1:0];
          z         <= (acc_nxt[N-1:0] == '0);
          ov        <= |acc_nxt[2*N-1:N];
          c_out     <= 1'b0;
          out_valid <= 1'b1;
          cnt       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_p.sv
// Bench for alu_seq_p: directed corner cases and random ops against a wide-arithmetic reference model.
module tb_alu_seq_p;

  localparam logic [2:0] MOV = 3'd0, NOT = 3'd1, MUL = 3'd2, AND = 3'd3;
  localparam logic [2:0] OR  = 3'd4, SUB = 3'd5, ADD = 3'd6, SLT = 3'd7;

  logic        clk, rst_n, rst8_n;
  logic [31:0] a, b, result;
  logic [2:0]  select, sel8;
  logic        in_valid, in_ready, out_valid, z, ov, c_out;
  logic [7:0]  a8, b8, result8;
  logic        iv8, ir8, ov8_vld, z8, ov8, c8;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_res;
  logic        m_c, m_ov;

  alu_seq_p #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .select(select), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .out_valid(out_valid), .z(z), .ov(ov), .c_out(c_out)
  );

  alu_seq_p #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .a(a8), .b(b8), .select(sel8), .in_valid(iv8),
    .in_ready(ir8), .result(result8), .out_valid(ov8_vld), .z(z8), .ov(ov8), .c_out(c8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the operands as numbers.
  task automatic model(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb);
    longint sa, sb, sr;
    logic [63:0] p;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    case (op)
      MOV: m_res = aa;
      NOT: m_res = ~aa;
      AND: m_res = aa & bb;
      OR:  m_res = aa | bb;
      ADD: begin
        p = {32'd0, aa} + {32'd0, bb};
        m_res = p[31:0]; m_c = p[32];
        sr = sa + sb; m_ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      SUB: begin
        p = {32'd0, aa} - {32'd0, bb};
        m_res = p[31:0]; m_c = (aa >= bb);
        sr = sa - sb; m_ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      SLT: m_res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
        p = {32'd0, aa} * {32'd0, bb};
        m_res = p[31:0]; m_c = 1'b0; m_ov = (p[63:32] != 32'd0);
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic run_op(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb);
    int cyc;
    check("ready_before_op", in_ready, 1);
    a = aa; b = bb; select = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    model(op, aa, bb);
    if (op == MUL) begin
      cyc = 0;
      while (!in_ready && cyc < 100) begin
        if (out_valid) check("mul_early_valid", out_valid, 0);
        a = $urandom; b = $urandom; select = 3'($urandom); in_valid = 1'($urandom);
        cyc++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("mul_busy_cycles", cyc, 32);
    end
    check("out_valid", out_valid, 1);
    check("result", result, m_res);
    check("z", z, (m_res == 32'd0));
    check("c_out", c_out, m_c);
    check("ov", ov, m_ov);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic seen;
    logic [2:0] op;
    rst_n = 1'b0; rst8_n = 1'b0;
    a = '0; b = '0; select = '0; in_valid = 1'b0;
    a8 = '0; b8 = '0; sel8 = '0; iv8 = 1'b0;
    m_res = '0; m_c = 1'b0; m_ov = 1'b0;

    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_z", z, 1);
    check("rst_ov", ov, 0);
    check("rst_c", c_out, 0);
    check("rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; rst8_n = 1'b1;

    run_op(ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    check("add_wrap_res", result, 0);
    check("add_wrap_c", c_out, 1);
    run_op(SUB, 32'h8000_0000, 32'h0000_0001);
    check("sub_ovf_res", result, 32'h7FFF_FFFF);
    check("sub_ovf_ov", ov, 1);
    run_op(AND, 32'h0, 32'h0);
    check("and_hold_ov", ov, 1);
    check("and_hold_c", c_out, 1);
    @(negedge clk);
    check("idle_no_valid", out_valid, 0);

    run_op(MUL, 32'h0001_0000, 32'h0001_0000);
    check("mul_big_ov", ov, 1);
    check("mul_big_z", z, 1);

    run_op(OR, 32'h1234_0000, 32'h0000_5678);
    run_op(SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt_neg", result, 1);
    run_op(MOV, 32'hCAFE_F00D, 32'h0);
    @(negedge clk);
    check("b2b_then_idle", out_valid, 0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      run_op(op, pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check("gap_no_valid", out_valid, 0);
      end
    end

    // Narrow instance: reset in the middle of a multiply.
    a8 = 8'h0F; b8 = 8'h0F; sel8 = MUL; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (4) @(negedge clk);
    rst8_n = 1'b0;
    #1;
    check("n8_rst_ready", ir8, 1);
    check("n8_rst_result", result8, 0);
    check("n8_rst_z", z8, 1);
    check("n8_rst_valid", ov8_vld, 0);
    @(negedge clk);
    rst8_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov8_vld) seen = 1'b1;
    end
    check("n8_abort_no_valid", seen, 0);
    check("n8_idle_result", result8, 0);

    a8 = 8'h0F; b8 = 8'h0F; sel8 = MUL; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    cyc = 0;
    while (!ir8 && cyc < 50) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      cyc++;
      @(negedge clk);
    end
    check("n8_mul_cycles", cyc, 8);
    check("n8_mul_valid", ov8_vld, 1);
    check("n8_mul_result", result8, 8'hE1);
    check("n8_mul_ov", ov8, 0);
    check("n8_mul_z", z8, 0);
    check("n8_mul_c", c8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
